ps2_key_rx: RTL and testbench

Parametrised PS/2 keyboard receiver with filtered clock sampling, frame timeout, E0/F0 prefix decoding and shift-aware ASCII translation. It replaces the single-byte ASCII decoder in the keyboard path. It emits complete key events (make/break, extended, scan code, ASCII) through a configurable-depth FIFO with a valid/ready handshake. It sits between the PS/2 pins and the game input controller, in the clock_27mhz domain.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_key_rx_frame.sv | 91 +++++++++
 rtl/ps2_key_rx.sv | 85 ++++++++
 tb/tb_ps2_key_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, state types, event record and scan-code-to-ASCII map
package ps2_pkg;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
  typedef enum logic [1:0] {P_BASE, P_EXT, P_BRK, P_EXT_BRK} pfx_state_t;
  typedef struct packed {
    logic ext;
    logic brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } key_ev_t;
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift);
    logic [15:0] p;
    case (code)
      8'h1C: p = 16'h6141; 8'h32: p = 16'h6242; 8'h21: p = 16'h6343; 8'h23: p = 16'h6444;
      8'h24: p = 16'h6545; 8'h2B: p = 16'h6646; 8'h34: p = 16'h6747; 8'h33: p = 16'h6848;
      8'h43: p = 16'h6949; 8'h3B: p = 16'h6A4A; 8'h42: p = 16'h6B4B; 8'h4B: p = 16'h6C4C;
      8'h3A: p = 16'h6D4D; 8'h31: p = 16'h6E4E; 8'h44: p = 16'h6F4F; 8'h4D: p = 16'h7050;
      8'h15: p = 16'h7151; 8'h2D: p = 16'h7252; 8'h1B: p = 16'h7353; 8'h2C: p = 16'h7454;
      8'h3C: p = 16'h7555; 8'h2A: p = 16'h7656; 8'h1D: p = 16'h7757; 8'h22: p = 16'h7858;
      8'h35: p = 16'h7959; 8'h1A: p = 16'h7A5A;
      8'h45: p = 16'h3029; 8'h16: p = 16'h3121; 8'h1E: p = 16'h3240; 8'h26: p = 16'h3323;
      8'h25: p = 16'h3424; 8'h2E: p = 16'h3525; 8'h36: p = 16'h365E; 8'h3D: p = 16'h3726;
      8'h3E: p = 16'h382A; 8'h46: p = 16'h3928;
      8'h0E: p = 16'h607E; 8'h4E: p = 16'h2D5F; 8'h55: p = 16'h3D2B; 8'h54: p = 16'h5B7B;
      8'h5B: p = 16'h5D7D; 8'h5D: p = 16'h5C7C; 8'h4C: p = 16'h3B3A; 8'h52: p = 16'h2722;
      8'h41: p = 16'h2C3C; 8'h49: p = 16'h2E3E; 8'h4A: p = 16'h2F3F;
      8'h29: p = 16'h2020; 8'h5A: p = 16'h0D0D; 8'h66: p = 16'h0808; 8'h0D: p = 16'h0909;
      default: p = 16'h0000;
    endcase
    return shift ? p[7:0] : p[15:8];
  endfunction
endpackage

// File: rtl/ps2_key_rx_frame.sv
// ps2_frame_rx: synchronise and filter PS/2 pins, deframe 11-bit frames with parity/stop/timeout checks
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clock_27mhz,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] c_s, d_s;
  logic filt, fall, par_ok, err_n, done_n, tmo;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] sh;
  frame_state_t state, state_n;
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      c_s <= '1;
      d_s <= '1;
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      c_s <= {c_s[0], ps2c};
      d_s <= {d_s[0], ps2d};
      fall <= 1'b0;
      if (c_s[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fcnt <= '0;
        filt <= c_s[1];
        fall <= filt;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  assign tmo = state != F_IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock_27mhz) state <= reset ? F_IDLE : state_n;
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    done_n = 1'b0;
    if (tmo) begin
      state_n = F_IDLE;
      err_n = 1'b1;
    end else if (fall) begin
      case (state)
        F_IDLE: begin
          state_n = d_s[1] ? F_IDLE : F_DATA;
          err_n = d_s[1];
        end
        F_DATA: state_n = bcnt == 3'd7 ? F_PARITY : F_DATA;
        F_PARITY: state_n = F_STOP;
        default: begin
          state_n = F_IDLE;
          done_n = d_s[1] && par_ok;
          err_n = !(d_s[1] && par_ok);
        end
      endcase
    end
  end
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      tcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      par_ok <= 1'b0;
      data_byte <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tcnt <= (state == F_IDLE || fall) ? '0 : tcnt + 1'b1;
      byte_valid <= done_n;
      frame_err <= err_n;
      if (done_n) data_byte <= sh;
      if (state == F_IDLE) bcnt <= '0;
      if (fall && state == F_DATA) begin
        sh <= {d_s[1], sh[7:1]};
        bcnt <= bcnt + 1'b1;
      end
      if (fall && state == F_PARITY) par_ok <= ^{sh, d_s[1]};
    end
  end
endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver decoding E0/F0 prefixes and shift-aware ASCII into an event FIFO
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clock_27mhz,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] ascii,
  output logic       shift_held,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] rx_byte;
  logic rx_valid, push, pop, wr, full, ext, brk, lsh, rsh;
  pfx_state_t pfx, pfx_n;
  key_ev_t ev, head;
  key_ev_t mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .clock_27mhz(clock_27mhz),
    .reset(reset),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .data_byte(rx_byte),
    .byte_valid(rx_valid),
    .frame_err(frame_err)
  );
  assign ext = pfx == P_EXT || pfx == P_EXT_BRK;
  assign brk = pfx == P_BRK || pfx == P_EXT_BRK;
  assign ev = {ext, brk, rx_byte, (ext || brk) ? 8'h00 : ps2_to_ascii(rx_byte, shift_held)};
  always_ff @(posedge clock_27mhz) pfx <= reset ? P_BASE : pfx_n;
  always_comb begin
    pfx_n = pfx;
    push = 1'b0;
    if (rx_valid) begin
      if (pfx == P_BASE && rx_byte == PS2_PFX_EXT) pfx_n = P_EXT;
      else if ((pfx == P_BASE || pfx == P_EXT) && rx_byte == PS2_PFX_BRK) pfx_n = ext ? P_EXT_BRK : P_BRK;
      else begin
        pfx_n = P_BASE;
        push = 1'b1;
      end
    end
  end
  assign pop = key_valid && key_ready;
  assign full = cnt == (AW + 1)'(FIFO_DEPTH);
  assign wr = push && (!full || pop);
  assign key_valid = cnt != '0;
  assign head = mem[rp];
  assign key_code = key_valid ? head.code : 8'h00;
  assign key_ext = key_valid && head.ext;
  assign key_break = key_valid && head.brk;
  assign ascii = key_valid ? head.ascii : 8'h00;
  assign shift_held = lsh || rsh;
  always_ff @(posedge clock_27mhz) if (wr) mem[wp] <= ev;
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      lsh <= 1'b0;
      rsh <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW + 1)'(wr) - (AW + 1)'(pop);
      if (pop) overflow <= 1'b0;
      if (push && !wr) overflow <= 1'b1;
      if (push && !ext && rx_byte == PS2_LSHIFT) lsh <= !brk;
      if (push && !ext && rx_byte == PS2_RSHIFT) rsh <= !brk;
    end
  end
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: scoreboard bench driving PS/2 frames and checking popped key events
module tb_ps2_key_rx;
  localparam int H = 15;
  localparam int TMO = 300;
  logic clock_27mhz = 1'b0, reset = 1'b1, ps2c = 1'b1, ps2d = 1'b1, key_ready = 1'b0;
  logic key_valid, key_ext, key_break, shift_held, frame_err, overflow;
  logic [7:0] key_code, ascii;
  int n_chk = 0, n_fail = 0, n_err = 0, e0 = 0;
  logic [17:0] sb [$];
  always #5 clock_27mhz = ~clock_27mhz;
  ps2_key_rx #(.FIFO_DEPTH(4), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_27mhz(clock_27mhz),
    .reset(reset),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_break(key_break),
    .ascii(ascii),
    .shift_held(shift_held),
    .frame_err(frame_err),
    .overflow(overflow)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock_27mhz);
    #1;
  endtask
  task automatic send_bit(input logic b);
    ps2d = b;
    tick(H);
    ps2c = 1'b0;
    tick(H);
    ps2c = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(!bad_stop);
    ps2d = 1'b1;
    tick(3 * H);
  endtask
  task automatic exp_ev(input logic e, input logic br, input logic [7:0] c, input logic [7:0] a);
    sb.push_back({e, br, c, a});
  endtask
  task automatic drain(input string name);
    int t = 0;
    key_ready = 1'b1;
    while ((sb.size() != 0 || key_valid) && t < 200) begin
      tick(1);
      t++;
    end
    check(name, sb.size(), 0);
  endtask
  initial forever begin
    @(negedge clock_27mhz);
    if (frame_err) n_err++;
    if (!reset && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got %h expected none", {key_ext, key_break, key_code, ascii});
      end else check("event", {key_ext, key_break, key_code, ascii}, sb.pop_front());
    end
  end
  initial begin
    tick(5);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 8'h00);
    check("rst_flags", {key_ext, key_break, shift_held, frame_err, overflow}, 0);
    check("rst_ascii", ascii, 8'h00);
    reset = 1'b0;
    tick(5);
    exp_ev(0, 0, 8'h1C, 8'h61);
    send(8'h1C);
    check("hold_valid", key_valid, 1);
    check("hold_code", key_code, 8'h1C);
    check("hold_ascii", ascii, 8'h61);
    tick(50);
    check("hold_stable", {key_valid, key_code, ascii}, {1'b1, 8'h1C, 8'h61});
    exp_ev(0, 1, 8'h1C, 8'h00);
    send(8'hF0);
    send(8'h1C);
    drain("drain_make_break");
    exp_ev(0, 0, 8'h12, 8'h00);
    send(8'h12);
    check("shift_on", shift_held, 1);
    exp_ev(0, 0, 8'h1C, 8'h41);
    send(8'h1C);
    exp_ev(0, 1, 8'h12, 8'h00);
    send(8'hF0);
    send(8'h12);
    check("shift_off", shift_held, 0);
    exp_ev(0, 0, 8'h1C, 8'h61);
    send(8'h1C);
    drain("drain_shift");
    exp_ev(1, 0, 8'h75, 8'h00);
    send(8'hE0);
    send(8'h75);
    exp_ev(1, 1, 8'h75, 8'h00);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    drain("drain_ext");
    e0 = n_err;
    send(8'h1C, 1'b1, 1'b0);
    send(8'h1C, 1'b0, 1'b1);
    exp_ev(0, 0, 8'h16, 8'h31);
    send(8'h16);
    drain("drain_errs");
    check("par_stop_errs", n_err - e0, 2);
    e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2d = 1'b1;
    tick(TMO + 50);
    check("timeout_err", n_err - e0, 1);
    exp_ev(0, 0, 8'h29, 8'h20);
    send(8'h29);
    drain("drain_timeout");
    key_ready = 1'b0;
    exp_ev(0, 0, 8'h15, 8'h71);
    exp_ev(0, 0, 8'h1D, 8'h77);
    exp_ev(0, 0, 8'h24, 8'h65);
    exp_ev(0, 0, 8'h2D, 8'h72);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    check("not_full_ovf", overflow, 0);
    send(8'h2C);
    send(8'h35);
    check("ovf_set", overflow, 1);
    check("ovf_head", key_code, 8'h15);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    tick(1);
    check("ovf_clear", overflow, 0);
    check("next_head", key_code, 8'h1D);
    drain("drain_fifo");
    e0 = n_err;
    ps2d = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      ps2c = 1'b0;
      tick(k);
      ps2c = 1'b1;
      tick(20);
    end
    ps2d = 1'b1;
    tick(TMO + 50);
    check("glitch_errs", n_err - e0, 0);
    check("glitch_no_event", key_valid, 0);
    exp_ev(0, 0, 8'h45, 8'h30);
    send(8'h45);
    drain("drain_glitch");
    e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ps2d = 1'b1;
    tick(TMO + 50);
    check("reset_mid_errs", n_err - e0, 0);
    exp_ev(0, 0, 8'h1C, 8'h61);
    send(8'h1C);
    drain("drain_reset");
    check("final_ovf", overflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
